// File: rtl/sr_latch_checker_if.sv
// sr_latch_checker_if
//  Bundles the S/R latch stimulus, the observed latch outputs and the checker
//  results into one connection.
//  master : the latch/stimulus side, drives en/S/R/Q/Qbar, reads results
//  slave  : the checker, reads en/S/R/Q/Qbar, drives results
//  Signals:
//    en, S, R, Q, Qbar                  stimulus and latch outputs
//    exp_q, model_valid, settled        reference model / FSM status
//    err, forbidden                     1-cycle event pulses
//    err_count[ERR_CNT_W]               saturating failed-interval count
interface sr_latch_checker_if #(
  parameter int unsigned ERR_CNT_W = 8
) ();
  logic                 en;
  logic                 S;
  logic                 R;
  logic                 Q;
  logic                 Qbar;
  logic                 exp_q;
  logic                 model_valid;
  logic                 settled;
  logic                 err;
  logic                 forbidden;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output en, S, R, Q, Qbar,
    input  exp_q, model_valid, settled, err, forbidden, err_count
  );

  modport slave (
    input  en, S, R, Q, Qbar,
    output exp_q, model_valid, settled, err, forbidden, err_count
  );
endinterface

// File: rtl/sr_latch_checker.sv
// sr_latch_checker
//  Clocked response checker for an S/R latch. Samples S/R and the latch Q/Qbar,
//  keeps a cycle-accurate reference model of the latch, waits SETTLE_CYCLES
//  after every input change and then checks Q/Qbar against the model, flagging
//  the first mismatch of each input interval and every entry into S=R=1.
//  Ports:
//    clk   in   rising-edge clock
//    rst   in   asynchronous reset, active high
//    bus   slave modport of sr_latch_checker_if (stimulus in, results out)
module sr_latch_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  sr_latch_checker_if.slave bus
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MONITOR = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;

  logic                 r_s_d;
  logic                 r_r_d;
  logic                 r_exp_q;
  logic                 r_model_valid;
  logic                 r_settled;
  logic                 r_err;
  logic                 r_forbidden;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic                 r_int_err;

  logic                 w_change;
  logic                 w_check_fail;
  logic                 w_exp_q_nxt;
  logic                 w_model_valid_nxt;
  logic                 w_settled_nxt;
  logic                 w_err_nxt;
  logic                 w_forbidden_nxt;
  logic [ERR_CNT_W-1:0] w_err_count_nxt;
  logic                 w_int_err_nxt;

  assign w_change = ({bus.S, bus.R} != {r_s_d, r_r_d});

  // FSM state and settle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: en low dominates everything, an input change restarts settling
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!bus.en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = CNT_RELOAD;
        end
        ST_SETTLE: begin
          if (w_change) begin
            w_cnt_nxt = CNT_RELOAD;
          end else if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = ST_MONITOR;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        ST_MONITOR: begin
          if (w_change) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = CNT_RELOAD;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs and reference model, computed for the next edge
  always_comb begin
    w_exp_q_nxt       = r_exp_q;
    w_model_valid_nxt = r_model_valid;
    case ({bus.S, bus.R})
      2'b10: begin
        w_exp_q_nxt       = 1'b1;
        w_model_valid_nxt = 1'b1;
      end
      2'b01: begin
        w_exp_q_nxt       = 1'b0;
        w_model_valid_nxt = 1'b1;
      end
      // 11 poisons the model; a following 00 is a race, so validity stays low
      2'b11:   w_model_valid_nxt = 1'b0;
      default: ;
    endcase

    // A change edge starts a new interval and is never itself checked
    w_check_fail = (r_state == ST_MONITOR) && bus.en && !w_change && r_model_valid &&
                   ((bus.Q != r_exp_q) || (bus.Qbar == bus.Q));

    w_err_nxt       = w_check_fail && !r_int_err;
    w_int_err_nxt   = w_change ? 1'b0 : (r_int_err | w_check_fail);
    w_err_count_nxt = r_err_count;
    if (w_err_nxt && (r_err_count != {ERR_CNT_W{1'b1}})) begin
      w_err_count_nxt = r_err_count + ERR_CNT_W'(1);
    end
    w_forbidden_nxt = bus.en && w_change && bus.S && bus.R;
    w_settled_nxt   = (w_state_nxt == ST_MONITOR);
  end

  // Output, model and history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_d         <= 1'b0;
      r_r_d         <= 1'b0;
      r_exp_q       <= 1'b0;
      r_model_valid <= 1'b0;
      r_settled     <= 1'b0;
      r_err         <= 1'b0;
      r_forbidden   <= 1'b0;
      r_err_count   <= '0;
      r_int_err     <= 1'b0;
    end else begin
      r_s_d         <= bus.S;
      r_r_d         <= bus.R;
      r_exp_q       <= w_exp_q_nxt;
      r_model_valid <= w_model_valid_nxt;
      r_settled     <= w_settled_nxt;
      r_err         <= w_err_nxt;
      r_forbidden   <= w_forbidden_nxt;
      r_err_count   <= w_err_count_nxt;
      r_int_err     <= w_int_err_nxt;
    end
  end

  assign bus.exp_q       = r_exp_q;
  assign bus.model_valid = r_model_valid;
  assign bus.settled     = r_settled;
  assign bus.err         = r_err;
  assign bus.forbidden   = r_forbidden;
  assign bus.err_count   = r_err_count;

endmodule
